// File: rtl/nios2_pio_gpio_if.sv
// Avalon-MM slave bus bundle for nios2_pio_gpio.
// Writes complete on every clk edge where chipselect & ~write_n (no wait states).
// readdata is valid in the same cycle as address, with no read strobe.
interface nios2_pio_gpio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_pio_gpio.sv
// WIDTH-bit Avalon-MM GPIO with direction, set/clear, synchronised inputs, edge capture and irq.
// Define NIOS2_PIO_OPEN_DRAIN_EN for open-drain pads; push-pull otherwise.
module nios2_pio_gpio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  nios2_pio_gpio_if.slave    bus,
  input  logic [WIDTH-1:0]   pin_in,
  output logic [WIDTH-1:0]   pin_out,
  output logic [WIDTH-1:0]   pin_oe,
  output logic               irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [ARM_W-1:0] r_arm_cnt;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_sel_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_data_out_nxt;
  logic [WIDTH-1:0] w_data_rd;
  logic [WIDTH-1:0] w_rd;
  logic             w_armed;
  logic             w_unused_wdata;

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_wdata        = bus.writedata[WIDTH-1:0];
  assign w_unused_wdata = ^bus.writedata;
  assign w_sync_in      = r_sync[SYNC_STAGES-1];
  assign w_armed        = (r_arm_cnt == ARM_W'(ARM_CYCLES));

  always_comb begin
    w_sel_edge = '0;
    case (EDGE_TYPE)
      0:       w_sel_edge = w_sync_in & ~r_prev;
      1:       w_sel_edge = ~w_sync_in & r_prev;
      default: w_sel_edge = w_sync_in ^ r_prev;
    endcase
  end

  assign w_clr = (w_wr && bus.address == 3'd3) ? w_wdata : '0;

  always_comb begin
    w_data_out_nxt = r_data_out;
    if (w_wr) begin
      case (bus.address)
        3'd0:    w_data_out_nxt = w_wdata;
        3'd4:    w_data_out_nxt = r_data_out | w_wdata;
        3'd5:    w_data_out_nxt = r_data_out & ~w_wdata;
        default: w_data_out_nxt = r_data_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev     <= '0;
      r_data_out <= OUT_RESET;
      r_dir      <= DIR_RESET;
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_arm_cnt  <= '0;
    end else begin
      r_sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev     <= w_sync_in;
      r_data_out <= w_data_out_nxt;
      if (w_wr && bus.address == 3'd1) r_dir  <= w_wdata;
      if (w_wr && bus.address == 3'd2) r_mask <= w_wdata;
      // A new edge in the same cycle as a clearing write keeps the bit set.
      r_edge_cap <= (r_edge_cap & ~w_clr) | (w_armed ? w_sel_edge : '0);
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

`ifdef NIOS2_PIO_OPEN_DRAIN_EN
  // Output bits read back the pad level so bus contention and clock stretching are visible.
  assign w_data_rd = w_sync_in;
  assign pin_out   = '0;
  assign pin_oe    = r_dir & ~r_data_out;
`else
  assign w_data_rd = (r_dir & r_data_out) | (~r_dir & w_sync_in);
  assign pin_out   = r_data_out;
  assign pin_oe    = r_dir;
`endif

  always_comb begin
    w_rd = '0;
    case (bus.address)
      3'd0:    w_rd = w_data_rd;
      3'd1:    w_rd = r_dir;
      3'd2:    w_rd = r_mask;
      3'd3:    w_rd = r_edge_cap;
      default: w_rd = '0;
    endcase
  end

  always_comb begin
    bus.readdata            = '0;
    bus.readdata[WIDTH-1:0] = w_rd;
  end

  assign irq = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_nios2_pio_gpio.sv
// Self-checking bench for nios2_pio_gpio: directed vectors, expected-value queue and monitor.
// Expectations follow NIOS2_PIO_OPEN_DRAIN_EN when it is defined.
module tb_nios2_pio_gpio;
  localparam int W = 8;
`ifdef NIOS2_PIO_OPEN_DRAIN_EN
  localparam bit OD = 1'b1;
`else
  localparam bit OD = 1'b0;
`endif
  localparam int S_RD  = 0;
  localparam int S_PO  = 1;
  localparam int S_POE = 2;
  localparam int S_IRQ = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  nios2_pio_gpio_if bus();
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_out;
  logic [W-1:0] pin_oe;
  logic         irq;

  nios2_pio_gpio #(
    .WIDTH(W), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  logic [2:0]  addr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  event        chk_ev;

  function automatic string sel_name(input int s);
    case (s)
      S_RD:    return "readdata";
      S_PO:    return "pin_out";
      S_POE:   return "pin_oe";
      default: return "irq";
    endcase
  endfunction

  initial begin
    forever begin
      @(chk_ev);
      #1;
      begin
        int          s;
        logic [31:0] e;
        logic [31:0] act;
        logic [2:0]  a;
        s = sel_q.pop_front();
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        case (s)
          S_RD:    act = bus.readdata;
          S_PO:    act = 32'(pin_out);
          S_POE:   act = 32'(pin_oe);
          default: act = 32'(irq);
        endcase
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL #%0d %s addr=%0d: got %h expected %h at %0t",
                   n_checks, sel_name(s), a, act, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input int s, input logic [2:0] a, input logic [31:0] e);
    bus.address = a;
    exp_q.push_back(e);
    sel_q.push_back(s);
    addr_q.push_back(a);
    -> chk_ev;
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    pin_in         = '0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(S_PO,  0, OD ? 32'h00 : 32'hA5);
    chk(S_POE, 0, OD ? 32'h0A : 32'h0F);
    chk(S_IRQ, 0, 32'h0);
    chk(S_RD,  2, 32'h0);
    @(negedge clk);
    chk(S_RD, 3, 32'h0);
    chk(S_RD, 0, OD ? 32'h00 : 32'h05);
    chk(S_RD, 1, 32'h0F);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // set / clear
    wr(0, 32'h3C);
    chk(S_PO, 0, OD ? 32'h0 : 32'h3C);
    wr(4, 32'h81);
    chk(S_PO, 0, OD ? 32'h0 : 32'hBD);
    chk(S_RD, 0, OD ? 32'h00 : 32'h0D);
    wr(5, 32'h0C);
    chk(S_PO,  0, OD ? 32'h0 : 32'hB1);
    chk(S_POE, 0, OD ? 32'h0E : 32'h0F);
    chk(S_RD,  4, 32'h0);
    chk(S_RD,  5, 32'h0);
    wr(4, 32'hFFFF_FF00);
    chk(S_PO, 0, OD ? 32'h0 : 32'hB1);

    // edge latency: pin_in[2] rises just before edge k
    wr(1, 32'h00);
    wr(2, 32'h04);
    pin_in = 8'h04;
    @(negedge clk);
    chk(S_RD, 0, 32'h00);
    chk(S_RD, 3, 32'h00);
    @(negedge clk);
    chk(S_RD,  0, 32'h04);
    chk(S_RD,  3, 32'h00);
    chk(S_IRQ, 0, 32'h0);
    @(negedge clk);
    chk(S_RD,  3, 32'h04);
    chk(S_IRQ, 0, 32'h1);
    wr(3, 32'h04);
    chk(S_IRQ, 0, 32'h0);
    chk(S_RD,  3, 32'h00);

    // falling edge ignored, then clear racing a new rising edge
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    chk(S_RD, 3, 32'h00);
    pin_in = 8'h04;
    @(negedge clk);
    wr(3, 32'h04);
    chk(S_RD,  3, 32'h04);
    chk(S_IRQ, 0, 32'h1);
    @(negedge clk);
    chk(S_RD, 3, 32'h04);
    wr(3, 32'h04);
    chk(S_RD,  3, 32'h00);
    chk(S_IRQ, 0, 32'h0);

    // mixed direction readback and reserved addresses
    wr(1, 32'hF0);
    chk(S_RD,  0, OD ? 32'h04 : 32'hB4);
    chk(S_POE, 0, OD ? 32'h40 : 32'hF0);
    wr(6, 32'hFF);
    chk(S_RD, 6, 32'h0);
    chk(S_RD, 7, 32'h0);
    chk(S_PO, 0, OD ? 32'h0 : 32'hB1);

    // reset with a pending write and pins high: no spurious capture after reset
    @(negedge clk);
    pin_in         = 8'hFF;
    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h00;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(S_RD, 3, 32'h00);
    end
    chk(S_PO,  0, OD ? 32'h0 : 32'hA5);
    chk(S_POE, 0, OD ? 32'h0A : 32'h0F);
    chk(S_RD,  2, 32'h00);
    @(negedge clk);
    chk(S_RD, 1, 32'h0F);

    // single open-drain style line on bit 0
    wr(1, 32'h01);
    wr(0, 32'h00);
    chk(S_POE, 0, 32'h01);
    chk(S_PO,  0, 32'h00);
    wr(0, 32'h01);
    chk(S_POE, 0, OD ? 32'h00 : 32'h01);
    chk(S_PO,  0, OD ? 32'h00 : 32'h01);
    pin_in = 8'h00;
    repeat (3) @(negedge clk);
    chk(S_RD, 0, OD ? 32'h00 : 32'h01);

    // ---------------- report ----------------
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
